// File: rtl/frame_sched_pkg.sv
// Shared types, default clamp limits and the clamp helper for the
// frame-synchronous mouse input scheduler.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } sched_state_t;

    typedef logic [11:0] pos_t;

    localparam pos_t DEF_XPOS_MAX = 12'd1023;
    localparam pos_t DEF_YPOS_MAX = 12'd767;

    function automatic pos_t clamp_pos(input pos_t value, input pos_t max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/frame_input_scheduler_if.sv
// Bus between the mouse resynchroniser / timing chain and the scheduler,
// plus the req/ack handshake towards the draw logic.
interface frame_input_scheduler_if;
    import frame_sched_pkg::*;

    logic       vblnk;
    pos_t       xpos_in;
    pos_t       ypos_in;
    logic       left_in;
    logic       upd_ack;
    pos_t       xpos_out;
    pos_t       ypos_out;
    logic       left_out;
    logic       click_pulse;
    logic       frame_tick;
    logic       upd_req;
    logic [7:0] missed_cnt;

    modport master (
        input  vblnk, xpos_in, ypos_in, left_in, upd_ack,
        output xpos_out, ypos_out, left_out, click_pulse, frame_tick, upd_req, missed_cnt
    );

    modport slave (
        output vblnk, xpos_in, ypos_in, left_in, upd_ack,
        input  xpos_out, ypos_out, left_out, click_pulse, frame_tick, upd_req, missed_cnt
    );

endinterface

// File: rtl/frame_debounce.sv
// Frame-rate button debouncer: takes one sample per enable pulse and changes
// level only after DEB_FRAMES consecutive differing samples.
module frame_debounce #(
    parameter int DEB_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic level,
    output logic rise
);

    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] cnt_inc;

    // Counter is widened by one bit so the DEB_FRAMES compare cannot wrap.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + 5'd1;
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (en) begin
            if (din == level_q) begin
                cnt_d = 4'd0;
            end else if (cnt_inc == 5'(DEB_FRAMES)) begin
                level_d = din;
                cnt_d   = 4'd0;
                rise_d  = din;
            end else begin
                cnt_d = cnt_inc[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/frame_input_scheduler.sv
// Samples mouse position/button once per vblank start, clamps and debounces them,
// and offers each sample to the draw logic through a req/ack handshake.
module frame_input_scheduler
    import frame_sched_pkg::*;
#(
    parameter pos_t XPOS_MAX   = DEF_XPOS_MAX,
    parameter pos_t YPOS_MAX   = DEF_YPOS_MAX,
    parameter int   DEB_FRAMES = 2
) (
    input  logic                    clk65MHz,
    input  logic                    rst,
    frame_input_scheduler_if.master bus
);

    sched_state_t state_q, state_d;
    logic         vblnk_q, vblnk_d;
    logic         armed_q, armed_d;
    pos_t         xpos_q, xpos_d;
    pos_t         ypos_q, ypos_d;
    logic         frame_tick_q, frame_tick_d;
    logic [7:0]   missed_q, missed_d;
    logic         vb_rise;
    logic         accept;
    logic         deb_level;
    logic         deb_rise;

    // armed_q blocks the false edge seen when reset releases while vblnk is already high.
    assign vb_rise = bus.vblnk & ~vblnk_q & armed_q;
    assign accept  = vb_rise & (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        vblnk_d      = bus.vblnk;
        armed_d      = armed_q | ~bus.vblnk;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        frame_tick_d = 1'b0;
        missed_d     = missed_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = REQ;
                    xpos_d       = clamp_pos(bus.xpos_in, XPOS_MAX);
                    ypos_d       = clamp_pos(bus.ypos_in, YPOS_MAX);
                    frame_tick_d = 1'b1;
                end
            end
            REQ: begin
                // An ack in the same cycle as vblnk falling still counts as taken.
                if (bus.upd_ack) begin
                    state_d = bus.vblnk ? WAIT : IDLE;
                end else if (!bus.vblnk) begin
                    state_d = IDLE;
                    if (missed_q != 8'hFF) begin
                        missed_d = missed_q + 8'd1;
                    end
                end
            end
            WAIT: begin
                if (!bus.vblnk) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vblnk_q      <= 1'b0;
            armed_q      <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            frame_tick_q <= 1'b0;
            missed_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            vblnk_q      <= vblnk_d;
            armed_q      <= armed_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            frame_tick_q <= frame_tick_d;
            missed_q     <= missed_d;
        end
    end

    frame_debounce #(
        .DEB_FRAMES(DEB_FRAMES)
    ) u_debounce (
        .clk   (clk65MHz),
        .rst   (rst),
        .en    (accept),
        .din   (bus.left_in),
        .level (deb_level),
        .rise  (deb_rise)
    );

    assign bus.xpos_out    = xpos_q;
    assign bus.ypos_out    = ypos_q;
    assign bus.left_out    = deb_level;
    assign bus.click_pulse = deb_rise;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.upd_req     = (state_q == REQ);
    assign bus.missed_cnt  = missed_q;

endmodule

// File: tb/tb_frame_input_scheduler.sv
// Directed bench for frame_input_scheduler: reset, clamping, frame hold,
// debounce, handshake and missed-frame counting.
module tb_frame_input_scheduler;
    import frame_sched_pkg::*;

    logic clk65MHz = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk65MHz = ~clk65MHz;

    frame_input_scheduler_if bus ();

    frame_input_scheduler #(
        .XPOS_MAX   (12'd1023),
        .YPOS_MAX   (12'd767),
        .DEB_FRAMES (2)
    ) dut (
        .clk65MHz (clk65MHz),
        .rst      (rst),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk65MHz);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input pos_t x, input pos_t y, input logic l);
        bus.xpos_in = x;
        bus.ypos_in = y;
        bus.left_in = l;
    endtask

    task automatic frame_start();
        bus.vblnk = 1'b1;
        tick();
    endtask

    task automatic frame_end(input bit ack);
        if (ack) begin
            bus.upd_ack = 1'b1;
            tick();
            bus.upd_ack = 1'b0;
        end
        bus.vblnk = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset mid-frame with every input nonzero
        rst         = 1'b1;
        bus.vblnk   = 1'b1;
        bus.upd_ack = 1'b1;
        apply_stimulus(12'd100, 12'd200, 1'b1);
        tick();
        tick();
        check_output("rst_xpos", 32'(bus.xpos_out), 0);
        check_output("rst_ypos", 32'(bus.ypos_out), 0);
        check_output("rst_left", 32'(bus.left_out), 0);
        check_output("rst_click", 32'(bus.click_pulse), 0);
        check_output("rst_tick", 32'(bus.frame_tick), 0);
        check_output("rst_req", 32'(bus.upd_req), 0);
        check_output("rst_missed", 32'(bus.missed_cnt), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("release_in_vblnk_tick", 32'(bus.frame_tick), 0);
            check_output("release_in_vblnk_req", 32'(bus.upd_req), 0);
        end
        bus.vblnk   = 1'b0;
        bus.upd_ack = 1'b0;
        apply_stimulus(12'd100, 12'd200, 1'b0);
        tick();
        tick();

        // Clamp, one-cycle tick, frame hold, late ack
        apply_stimulus(12'd1500, 12'd900, 1'b0);
        frame_start();
        check_output("clamp_x", 32'(bus.xpos_out), 1023);
        check_output("clamp_y", 32'(bus.ypos_out), 767);
        check_output("tick_high", 32'(bus.frame_tick), 1);
        check_output("req_high", 32'(bus.upd_req), 1);
        bus.xpos_in = 12'd10;
        tick();
        check_output("tick_one_cycle", 32'(bus.frame_tick), 0);
        check_output("hold_x", 32'(bus.xpos_out), 1023);
        check_output("req_held", 32'(bus.upd_req), 1);
        repeat (3) tick();
        bus.upd_ack = 1'b1;
        tick();
        bus.upd_ack = 1'b0;
        check_output("req_drop_after_ack", 32'(bus.upd_req), 0);
        check_output("ack_no_miss", 32'(bus.missed_cnt), 0);
        tick();
        check_output("wait_req_low", 32'(bus.upd_req), 0);
        check_output("hold_x_wait", 32'(bus.xpos_out), 1023);
        bus.vblnk = 1'b0;
        tick();
        tick();
        frame_start();
        check_output("new_frame_x", 32'(bus.xpos_out), 10);
        check_output("new_frame_y", 32'(bus.ypos_out), 767);
        check_output("new_frame_req", 32'(bus.upd_req), 1);
        frame_end(1'b1);

        // Clamp boundaries
        apply_stimulus(12'd1023, 12'd767, 1'b0);
        frame_start();
        check_output("edge_x_max", 32'(bus.xpos_out), 1023);
        check_output("edge_y_max", 32'(bus.ypos_out), 767);
        frame_end(1'b1);
        apply_stimulus(12'd1024, 12'd768, 1'b0);
        frame_start();
        check_output("edge_x_over", 32'(bus.xpos_out), 1023);
        check_output("edge_y_over", 32'(bus.ypos_out), 767);
        frame_end(1'b1);
        apply_stimulus(12'd4095, 12'd0, 1'b0);
        frame_start();
        check_output("edge_x_4095", 32'(bus.xpos_out), 1023);
        check_output("edge_y_zero", 32'(bus.ypos_out), 0);
        frame_end(1'b1);

        // Debounce with DEB_FRAMES = 2
        apply_stimulus(12'd5, 12'd6, 1'b1);
        frame_start();
        check_output("deb_f1_level", 32'(bus.left_out), 0);
        check_output("deb_f1_click", 32'(bus.click_pulse), 0);
        frame_end(1'b1);
        frame_start();
        check_output("deb_f2_level", 32'(bus.left_out), 1);
        check_output("deb_f2_click", 32'(bus.click_pulse), 1);
        bus.left_in = 1'b0;
        tick();
        check_output("click_one_cycle", 32'(bus.click_pulse), 0);
        check_output("left_hold_midframe", 32'(bus.left_out), 1);
        frame_end(1'b1);
        frame_start();
        check_output("glitch_level", 32'(bus.left_out), 1);
        frame_end(1'b1);
        bus.left_in = 1'b1;
        frame_start();
        check_output("glitch_recover", 32'(bus.left_out), 1);
        frame_end(1'b1);
        bus.left_in = 1'b0;
        frame_start();
        check_output("release_f1_level", 32'(bus.left_out), 1);
        frame_end(1'b1);
        frame_start();
        check_output("release_f2_level", 32'(bus.left_out), 0);
        check_output("release_no_click", 32'(bus.click_pulse), 0);
        frame_end(1'b1);

        // Missed frames, ack racing vblnk fall, saturation
        for (int i = 0; i < 3; i++) begin
            frame_start();
            frame_end(1'b0);
        end
        check_output("missed_three", 32'(bus.missed_cnt), 3);
        frame_start();
        bus.upd_ack = 1'b1;
        bus.vblnk   = 1'b0;
        tick();
        bus.upd_ack = 1'b0;
        check_output("ack_race_req", 32'(bus.upd_req), 0);
        check_output("ack_race_missed", 32'(bus.missed_cnt), 3);
        tick();
        for (int i = 0; i < 252; i++) begin
            frame_start();
            frame_end(1'b0);
        end
        check_output("missed_255", 32'(bus.missed_cnt), 255);
        frame_start();
        frame_end(1'b0);
        check_output("missed_saturate", 32'(bus.missed_cnt), 255);

        // Async reset while requesting
        apply_stimulus(12'd300, 12'd400, 1'b0);
        frame_start();
        check_output("req_before_rst", 32'(bus.upd_req), 1);
        @(posedge clk65MHz);
        #3;
        rst = 1'b1;
        #1;
        check_output("rst_async_req", 32'(bus.upd_req), 0);
        check_output("rst_async_missed", 32'(bus.missed_cnt), 0);
        check_output("rst_async_x", 32'(bus.xpos_out), 0);
        tick();
        rst = 1'b0;
        tick();
        check_output("rst_release_no_tick", 32'(bus.frame_tick), 0);
        bus.vblnk = 1'b0;
        tick();
        tick();
        frame_start();
        check_output("resume_tick", 32'(bus.frame_tick), 1);
        check_output("resume_req", 32'(bus.upd_req), 1);
        check_output("resume_x", 32'(bus.xpos_out), 300);
        check_output("resume_y", 32'(bus.ypos_out), 400);
        bus.upd_ack = 1'b1;
        tick();
        bus.upd_ack = 1'b0;
        check_output("resume_ack", 32'(bus.upd_req), 0);
        check_output("resume_missed", 32'(bus.missed_cnt), 0);
        bus.vblnk = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
